reg_bank_param: RTL

REG_BANK_PARAM -- requirements
Module: reg_bank_param

---
 rtl/reg_bank_param.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_bank_param.sv
// Parameterised register bank: two registered read ports with write bypass,
// one write port, and a one-register-per-cycle clear sweep.
//
// state | meaning
// IDLE  | normal read/write operation, waiting for clr_req
// CLEAR | sweeping registers to zero, one index per edge, writes dropped
module reg_bank_param #(
  parameter int DATA_W = 26,
  parameter int NREGS  = 13,
  parameter int ADDR_W = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_RF,
  input  logic [ADDR_W-1:0]              A1,
  input  logic [ADDR_W-1:0]              A2,
  input  logic [ADDR_W-1:0]              A3,
  input  logic [DATA_W-1:0]              WD3,
  input  logic                           clr_req,
  output logic [DATA_W-1:0]              RD1,
  output logic [DATA_W-1:0]              RD2,
  output logic [NREGS-1:0][DATA_W-1:0]   registerBank,
  output logic                           busy,
  output logic                           addr_err
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W:0]  NREGS_A  = (ADDR_W + 1)'(NREGS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                      state_q, state_nxt;
  logic [IDX_W-1:0]            idx_q, idx_nxt;
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_nxt;
  logic [DATA_W-1:0]           rd1_nxt, rd2_nxt;
  logic                        a1_ok, a2_ok, a3_ok;
  logic                        wr_en, addr_err_nxt;
  logic [IDX_W-1:0]            a1_i, a2_i, a3_i;

  assign a1_ok = {1'b0, A1} < NREGS_A;
  assign a2_ok = {1'b0, A2} < NREGS_A;
  assign a3_ok = {1'b0, A3} < NREGS_A;
  assign a1_i  = A1[IDX_W-1:0];
  assign a2_i  = A2[IDX_W-1:0];
  assign a3_i  = A3[IDX_W-1:0];

  assign busy         = (state_q == CLEAR);
  assign wr_en        = we_RF && !busy && a3_ok;
  assign addr_err_nxt = !a1_ok || !a2_ok || (we_RF && !a3_ok);
  assign registerBank = regs_q;

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == IDX_LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Writes only happen in IDLE and clears only in CLEAR, so the two never collide.
  always_comb begin
    regs_nxt = regs_q;
    if (wr_en)
      regs_nxt[a3_i] = WD3;
    if (state_q == CLEAR)
      regs_nxt[idx_q] = '0;
    rd1_nxt = '0;
    rd2_nxt = '0;
    if (a1_ok)
      rd1_nxt = regs_nxt[a1_i];
    if (a2_ok)
      rd2_nxt = regs_nxt[a2_i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      regs_q   <= '0;
      RD1      <= '0;
      RD2      <= '0;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      idx_q    <= idx_nxt;
      regs_q   <= regs_nxt;
      RD1      <= rd1_nxt;
      RD2      <= rd2_nxt;
      addr_err <= addr_err_nxt;
    end
  end

endmodule
